// File: rtl/icache_refill.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icache_refill : AXI4 line-refill engine for the icache (critical word first).
// Rev 1.0
// ---------------------------------------------------------------------------
module icache_refill #(
  parameter int         LINE_WORDS = 8,
  parameter int         INDEX_BITS = 7,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  miss_req,
  input  logic [31:0]           miss_addr,
  output logic                  miss_ready,
  output logic                  crit_valid,
  output logic [31:0]           crit_data,
  output logic                  refill_done,
  output logic                  refill_err,
  output logic [3:0]            ram_wen,
  output logic [31:0]           ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  tag_wen,
  output logic [INDEX_BITS-1:0] tag_index,
  output logic [20:0]           tag_wdata,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam int OFF_W  = CNT_W + 2;
  localparam int TAG_LO = OFF_W + INDEX_BITS;

  localparam logic [CNT_W:0] CNT_FULL = (CNT_W+1)'(LINE_WORDS);
  localparam logic [CNT_W:0] CNT_LAST = (CNT_W+1)'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [31:OFF_W]   base_q, base_d;
  logic [CNT_W-1:0]  crit_off_q, crit_off_d;
  logic [CNT_W:0]    beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;
  logic              crit_valid_q, crit_valid_d;
  logic [31:0]       crit_data_q, crit_data_d;

  logic beat_fire, wr_fire, done;
  logic unused_bits;

  assign beat_fire   = (state_q == S_R) && rvalid;
  assign wr_fire     = beat_fire && (beat_cnt_q < CNT_FULL);
  assign done        = (state_q == S_DONE);
  assign unused_bits = ^{miss_addr[1:0], rresp[0]};

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    crit_off_d   = crit_off_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          base_d     = miss_addr[31:OFF_W];
          crit_off_d = miss_addr[OFF_W-1:2];
          state_d    = S_AR;
        end
      end
      S_AR: begin
        if (arready) begin
          beat_cnt_d = '0;
          state_d    = S_R;
        end
      end
      S_R: begin
        if (rvalid) begin
          if (beat_cnt_q != CNT_FULL) beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == {1'b0, crit_off_q}) begin
            crit_valid_d = 1'b1;
            crit_data_d  = rdata;
          end
          // Short bursts and overrun beats both leave the line unusable.
          err_d = err_q | rresp[1] | (rid != AXI_ID)
                | (beat_cnt_q >= CNT_FULL)
                | (rlast && (beat_cnt_q != CNT_LAST));
          if (rlast) state_d = S_DONE;
        end
      end
      default: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      crit_off_q   <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      crit_off_q   <= crit_off_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

  assign miss_ready  = (state_q == S_IDLE);
  assign crit_valid  = crit_valid_q;
  assign crit_data   = crit_data_q;
  assign refill_done = done;
  assign refill_err  = done & err_q;

  assign ram_wen   = {4{wr_fire}};
  assign ram_addr  = wr_fire ? {base_q, beat_cnt_q[CNT_W-1:0], 2'b00} : '0;
  assign ram_wdata = wr_fire ? rdata : '0;

  assign tag_wen   = done;
  assign tag_index = done ? base_q[TAG_LO-1:OFF_W] : '0;
  assign tag_wdata = done ? {~err_q, base_q[31:TAG_LO]} : '0;

  assign arid    = AXI_ID;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = (state_q == S_AR);
  assign araddr  = arvalid ? {base_q, {OFF_W{1'b0}}} : '0;
  assign rready  = (state_q == S_R);

endmodule
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_icache_refill : directed self-checking bench for icache_refill.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        resetn;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        miss_ready, crit_valid, refill_done, refill_err;
  logic [31:0] crit_data, ram_addr, ram_wdata, araddr, rdata;
  logic [3:0]  ram_wen, arid, rid;
  logic        tag_wen, arvalid, arready, rlast, rvalid, rready;
  logic [6:0]  tag_index;
  logic [20:0] tag_wdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  icache_refill dut (
    .clk(clk), .resetn(resetn), .miss_req(miss_req), .miss_addr(miss_addr),
    .miss_ready(miss_ready), .crit_valid(crit_valid), .crit_data(crit_data),
    .refill_done(refill_done), .refill_err(refill_err), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .tag_wen(tag_wen),
    .tag_index(tag_index), .tag_wdata(tag_wdata), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a miss in IDLE; on return the DUT is in AR with arready low.
  task automatic start_miss(input logic [31:0] a, input logic [31:0] base, input logic hold);
    miss_req  = 1'b1;
    miss_addr = a;
    #1 chk("miss_ready_idle", 32'(miss_ready), 32'd1);
    cyc();
    miss_req = hold;
    #1;
    chk("arvalid", 32'(arvalid), 32'd1);
    chk("araddr", araddr, base);
    chk("arlen", 32'(arlen), 32'd7);
    chk("miss_ready_ar", 32'(miss_ready), 32'd0);
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] id, input logic [1:0] resp,
                      input logic last, input logic wen_exp, input logic [31:0] addr_exp);
    rvalid = 1'b1;
    rdata  = d;
    rid    = id;
    rresp  = resp;
    rlast  = last;
    #1;
    chk("rready", 32'(rready), 32'd1);
    chk("arvalid_in_r", 32'(arvalid), 32'd0);
    chk("miss_ready_in_r", 32'(miss_ready), 32'd0);
    chk("ram_wen", 32'(ram_wen), wen_exp ? 32'hF : 32'h0);
    if (wen_exp) begin
      chk("ram_addr", ram_addr, addr_exp);
      chk("ram_wdata", ram_wdata, d);
    end
    cyc();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    rid    = 4'd0;
  endtask

  initial begin
    resetn = 1'b0; miss_req = 1'b0; miss_addr = '0; arready = 1'b0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (2) cyc();
    #1;
    chk("rst_miss_ready", 32'(miss_ready), 32'd1);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_ram_wen", 32'(ram_wen), 32'd0);
    chk("rst_tag_wen", 32'(tag_wen), 32'd0);
    chk("rst_done", 32'(refill_done), 32'd0);
    chk("rst_crit_valid", 32'(crit_valid), 32'd0);
    chk("rst_ar_const", {arid, arlen, 1'b0, arsize, 2'b0, arburst}, {4'd0, 8'd7, 1'b0, 3'd2, 2'b0, 2'd1});
    resetn = 1'b1;
    cyc();

    // Nominal refill, critical word 5
    start_miss(32'h1FC0_0014, 32'h1FC0_0000, 1'b0);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(32'hA0 + i, 4'd0, 2'b00, i == 7, 1'b1, 32'h1FC0_0000 + 4 * i);
      if (i == 5) begin
        #1;
        chk("nom_crit_valid", 32'(crit_valid), 32'd1);
        chk("nom_crit_data", crit_data, 32'hA5);
      end
    end
    #1;
    chk("nom_done", 32'(refill_done), 32'd1);
    chk("nom_err", 32'(refill_err), 32'd0);
    chk("nom_tag_wen", 32'(tag_wen), 32'd1);
    chk("nom_tag_wdata", 32'(tag_wdata), 32'h11FC00);
    chk("nom_tag_index", 32'(tag_index), 32'h00);
    cyc();
    #1;
    chk("nom_done_pulse", 32'(refill_done), 32'd0);
    chk("nom_crit_pulse", 32'(crit_valid), 32'd0);
    chk("nom_back_idle", 32'(miss_ready), 32'd1);

    // Backpressure on AR and R
    start_miss(32'h0000_1234, 32'h0000_1220, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      #1;
      chk("bp_arvalid", 32'(arvalid), 32'd1);
      chk("bp_araddr", araddr, 32'h0000_1220);
    end
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(32'hB0 + i, 4'd0, 2'b00, i == 7, 1'b1, 32'h0000_1220 + 4 * i);
      if (i < 7) begin
        #1;
        chk("bp_gap_wen", 32'(ram_wen), 32'd0);
        chk("bp_gap_rready", 32'(rready), 32'd1);
        if (i == 5) chk("bp_crit_data", crit_data, 32'hB5);
        cyc();
      end
    end
    #1;
    chk("bp_done", 32'(refill_done), 32'd1);
    chk("bp_err", 32'(refill_err), 32'd0);
    chk("bp_tag_wdata", 32'(tag_wdata), 32'h100001);
    chk("bp_tag_index", 32'(tag_index), 32'h11);
    cyc();

    // SLVERR on beat 3
    start_miss(32'h8000_0040, 32'h8000_0040, 1'b0);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(32'hC0 + i, 4'd0, (i == 3) ? 2'b10 : 2'b00, i == 7, 1'b1, 32'h8000_0040 + 4 * i);
      if (i == 0) begin
        #1 chk("se_crit_data", crit_data, 32'hC0);
      end
    end
    #1;
    chk("se_done", 32'(refill_done), 32'd1);
    chk("se_err", 32'(refill_err), 32'd1);
    chk("se_tag_wdata", 32'(tag_wdata), 32'h080000);
    chk("se_tag_index", 32'(tag_index), 32'h02);
    cyc();

    // Early rlast on beat 4
    start_miss(32'h0000_0000, 32'h0000_0000, 1'b0);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    for (int i = 0; i < 5; i++)
      beat(32'hE0 + i, 4'd0, 2'b00, i == 4, 1'b1, 32'h0000_0000 + 4 * i);
    #1;
    chk("er_done", 32'(refill_done), 32'd1);
    chk("er_err", 32'(refill_err), 32'd1);
    chk("er_tag_wen", 32'(tag_wen), 32'd1);
    cyc();
    rvalid = 1'b1;
    #1;
    chk("er_idle_rready", 32'(rready), 32'd0);
    chk("er_idle_wen", 32'(ram_wen), 32'd0);
    chk("er_idle_ready", 32'(miss_ready), 32'd1);
    rvalid = 1'b0;

    // Reset in the middle of a burst
    start_miss(32'h0000_2000, 32'h0000_2000, 1'b0);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    for (int i = 0; i < 3; i++)
      beat(32'hF0 + i, 4'd0, 2'b00, 1'b0, 1'b1, 32'h0000_2000 + 4 * i);
    rvalid = 1'b1;
    resetn = 1'b0;
    #1;
    chk("mr_miss_ready", 32'(miss_ready), 32'd1);
    chk("mr_arvalid", 32'(arvalid), 32'd0);
    chk("mr_rready", 32'(rready), 32'd0);
    chk("mr_ram_wen", 32'(ram_wen), 32'd0);
    chk("mr_tag_wen", 32'(tag_wen), 32'd0);
    cyc();
    #1 chk("mr_tag_wen_hold", 32'(tag_wen), 32'd0);
    resetn = 1'b1;
    rvalid = 1'b0;
    cyc();

    // Fresh AR after reset, miss_req held high through the whole refill
    start_miss(32'h0000_3000, 32'h0000_3000, 1'b1);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    for (int i = 0; i < 8; i++)
      beat(32'hD0 + i, (i == 2) ? 4'd1 : 4'd0, 2'b00, i == 7, 1'b1, 32'h0000_3000 + 4 * i);
    #1;
    chk("hm_done", 32'(refill_done), 32'd1);
    chk("hm_err_rid", 32'(refill_err), 32'd1);
    chk("hm_tag_wdata", 32'(tag_wdata), 32'h000003);
    chk("hm_done_arvalid", 32'(arvalid), 32'd0);
    chk("hm_done_ready", 32'(miss_ready), 32'd0);
    cyc();
    #1;
    chk("hm_idle_ready", 32'(miss_ready), 32'd1);
    chk("hm_idle_arvalid", 32'(arvalid), 32'd0);
    cyc();
    miss_req = 1'b0;
    #1;
    chk("hm_second_ar", 32'(arvalid), 32'd1);
    chk("hm_second_araddr", araddr, 32'h0000_3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
